pulse_generator: RTL

PULSE_GENERATOR -- requirements
Module: pulse_generator

---
 rtl/pulse_generator.sv | 115 +++++++++++
 1 files changed

// File: rtl/pulse_generator.sv
// Pulse generator. Each period is a linear rise to an apex, a linear fall back
// to baseline, then a flat stretch that can carry LFSR noise. Output is
// registered: one sample per enabled clock, and the block freezes when enable is low.
module pulse_generator #(
  parameter int PERIOD     = 200,
  parameter int RISE_SHIFT = 3,
  parameter int FALL_SHIFT = 4,
  parameter int NOISE_BITS = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  input  logic [15:0] baseline,
  input  logic [15:0] amplitude,
  input  logic        noise_en,
  output logic [15:0] data_out,
  output logic        data_valid,
  output logic        peak_marker,
  output logic [15:0] peak_count
);

  localparam int RISE_LEN = 1 << RISE_SHIFT;
  localparam int FALL_LEN = 1 << FALL_SHIFT;
  localparam int CW       = (PERIOD > 1) ? $clog2(PERIOD) : 1;

  // A period too short to hold the whole pulse plus one flat sample is rejected.
  if (PERIOD < RISE_LEN + FALL_LEN + 1) begin : g_cfg_err
    $error("pulse_generator: PERIOD too short for RISE_LEN+FALL_LEN+1");
  end
  if (NOISE_BITS < 1 || NOISE_BITS > 8) begin : g_noise_err
    $error("pulse_generator: NOISE_BITS must be 1..8");
  end

  typedef enum logic [1:0] {IDLE, RISE, FALL, FLAT} state_t;

  state_t          r_state;
  logic [CW-1:0]   r_cnt;
  logic [15:0]     r_base;
  logic [15:0]     r_amp;
  logic [15:0]     r_lfsr;

  logic [15:0]     w_b;
  logic [15:0]     w_a;
  logic [17:0]     w_rise_inc;
  logic [17:0]     w_fall_dec;
  logic [17:0]     w_sum;
  logic [15:0]     w_sample;
  logic [CW-1:0]   w_cnt_nxt;
  logic            w_peak;
  logic            w_lfsr_fb;

  // Phase owning a given counter value; state always names the phase of r_cnt.
  function automatic state_t phase_of(input logic [CW-1:0] c);
    if (32'(c) < RISE_LEN)                 return RISE;
    else if (32'(c) < RISE_LEN + FALL_LEN) return FALL;
    else                                   return FLAT;
  endfunction

  // At cnt==0 the shadow registers are being loaded this very cycle, so the
  // first sample of a period already uses the freshly sampled inputs.
  assign w_b = (r_cnt == '0) ? baseline  : r_base;
  assign w_a = (r_cnt == '0) ? amplitude : r_amp;

  assign w_rise_inc = 18'((32'(w_a) * (32'(r_cnt) + 32'd1)) >> RISE_SHIFT);
  assign w_fall_dec = 18'((32'(w_a) * (32'(r_cnt) - 32'(RISE_LEN) + 32'd1)) >> FALL_SHIFT);

  assign w_cnt_nxt = (32'(r_cnt) == PERIOD - 1) ? '0 : r_cnt + 1'b1;
  assign w_peak    = (32'(r_cnt) == RISE_LEN - 1);
  assign w_lfsr_fb = r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10];

  // Sample value for the current counter position, in 18 bits so overflow is visible.
  always_comb begin
    w_sum = {2'b00, w_b};
    case (r_state)
      IDLE, RISE: w_sum = {2'b00, w_b} + w_rise_inc;
      FALL:       w_sum = {2'b00, w_b} + {2'b00, w_a} - w_fall_dec;
      default:    if (noise_en) w_sum = {2'b00, w_b} + 18'(r_lfsr[NOISE_BITS-1:0]);
    endcase
  end

  // Saturate so the output never sets bit 15.
  assign w_sample = (w_sum > 18'h07FFF) ? 16'h7FFF : w_sum[15:0];

  // Sequencer: one sample per enabled cycle; everything but the valid/marker
  // flags holds while enable is low.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_cnt       <= '0;
      r_base      <= '0;
      r_amp       <= '0;
      r_lfsr      <= 16'hACE1;
      data_out    <= '0;
      data_valid  <= 1'b0;
      peak_marker <= 1'b0;
      peak_count  <= '0;
    end else if (enable) begin
      data_out    <= w_sample;
      data_valid  <= 1'b1;
      peak_marker <= w_peak;
      if (w_peak) peak_count <= peak_count + 16'd1;
      if (r_cnt == '0) begin
        r_base <= baseline;
        r_amp  <= amplitude;
      end
      r_cnt   <= w_cnt_nxt;
      r_state <= phase_of(w_cnt_nxt);
      r_lfsr  <= {r_lfsr[14:0], w_lfsr_fb};
    end else begin
      data_valid  <= 1'b0;
      peak_marker <= 1'b0;
    end
  end

endmodule
